// File: rtl/tl_pkg.sv
// tl_pkg: constants shared by the traffic-light controller and the traffic
// generator that models vehicle queues in front of it.
//   GREEN/YELLOW/RED/LEFT : 2-bit light encoding driven on La/Lb
//   QW_DEFAULT            : default width of each lane queue counter
package tl_pkg;

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;
    localparam logic [1:0] LEFT   = 2'b11;

    localparam int unsigned QW_DEFAULT = 4;

endpackage

// File: rtl/tl_lane_queue.sv
// tl_lane_queue: one saturating vehicle queue for a single lane.
//   clk, reset : clock, synchronous active-high reset
//   arr        : one-cycle arrival pulse
//   dep        : departure request (the lane currently has right of way)
//   count      : registered queue length
//   sensor     : queue non-empty, decoded from the registered count
//   took       : a vehicle actually leaves this cycle (dep on a non-empty queue)
//   lost       : an arrival is dropped this cycle (queue full, nothing leaving)
module tl_lane_queue
    import tl_pkg::*;
#(
    parameter int unsigned QW = QW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          arr,
    input  logic          dep,
    output logic [QW-1:0] count,
    output logic          sensor,
    output logic          took,
    output logic          lost
);

    logic full;

    assign full   = (count == '1);
    assign took   = dep && (count != '0);
    // A departure in the same cycle frees the slot, so a full queue with a
    // simultaneous departure accepts the arrival and holds its count.
    assign lost   = arr && !took && full;
    assign sensor = (count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (arr && !took && !full) begin
            count <= count + QW'(1);
        end else if (took && !arr) begin
            count <= count - QW'(1);
        end
    end

endmodule

// File: rtl/tl_traffic_gen.sv
// tl_traffic_gen: models four vehicle queues (A, B, A-left, B-left) in front
// of a traffic-light controller and reports sensors back to it.
//   clk, reset            : clock, synchronous active-high reset
//   La, Lb                : light state for street A / street B
//   arr_a/arr_b/arr_al/arr_bl : one-cycle vehicle arrival pulses
//   Ta/Tb/Tal/Tbl         : queue non-empty sensors (registered-count decode)
//   qa/qb/qal/qbl         : queue counts
//   departed              : running count of departed vehicles, wraps at 256
//   overflow              : sticky, an arrival was dropped on a full queue
//   conflict              : sticky, both streets non-RED in one cycle
// Build option: define TL_CONFLICT_CHK_EN to implement conflict detection;
// otherwise conflict is constant 0.
module tl_traffic_gen
    import tl_pkg::*;
#(
    parameter int unsigned QW = QW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    La,
    input  logic [1:0]    Lb,
    input  logic          arr_a,
    input  logic          arr_b,
    input  logic          arr_al,
    input  logic          arr_bl,
    output logic          Ta,
    output logic          Tb,
    output logic          Tal,
    output logic          Tbl,
    output logic [QW-1:0] qa,
    output logic [QW-1:0] qb,
    output logic [QW-1:0] qal,
    output logic [QW-1:0] qbl,
    output logic [7:0]    departed,
    output logic          overflow,
    output logic          conflict
);

    logic dep_a, dep_b, dep_al, dep_bl;
    logic took_a, took_b, took_al, took_bl;
    logic lost_a, lost_b, lost_al, lost_bl;
    logic [2:0] n_took;

    // Straight lanes move on GREEN, turn lanes on LEFT; YELLOW/RED hold.
    always_comb begin
        dep_a  = 1'b0;
        dep_al = 1'b0;
        unique case (La)
            GREEN:       dep_a  = 1'b1;
            LEFT:        dep_al = 1'b1;
            YELLOW, RED: ;
            default:     ;
        endcase
    end

    always_comb begin
        dep_b  = 1'b0;
        dep_bl = 1'b0;
        unique case (Lb)
            GREEN:       dep_b  = 1'b1;
            LEFT:        dep_bl = 1'b1;
            YELLOW, RED: ;
            default:     ;
        endcase
    end

    tl_lane_queue #(.QW(QW)) u_q_a (
        .clk(clk), .reset(reset), .arr(arr_a), .dep(dep_a),
        .count(qa), .sensor(Ta), .took(took_a), .lost(lost_a)
    );

    tl_lane_queue #(.QW(QW)) u_q_b (
        .clk(clk), .reset(reset), .arr(arr_b), .dep(dep_b),
        .count(qb), .sensor(Tb), .took(took_b), .lost(lost_b)
    );

    tl_lane_queue #(.QW(QW)) u_q_al (
        .clk(clk), .reset(reset), .arr(arr_al), .dep(dep_al),
        .count(qal), .sensor(Tal), .took(took_al), .lost(lost_al)
    );

    tl_lane_queue #(.QW(QW)) u_q_bl (
        .clk(clk), .reset(reset), .arr(arr_bl), .dep(dep_bl),
        .count(qbl), .sensor(Tbl), .took(took_bl), .lost(lost_bl)
    );

    assign n_took = 3'(took_a) + 3'(took_b) + 3'(took_al) + 3'(took_bl);

    always_ff @(posedge clk) begin
        if (reset) begin
            departed <= '0;
            overflow <= 1'b0;
        end else begin
            departed <= departed + 8'(n_took);
            if (lost_a || lost_b || lost_al || lost_bl) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef TL_CONFLICT_CHK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict <= 1'b0;
        end else if ((La != RED) && (Lb != RED)) begin
            conflict <= 1'b1;
        end
    end
`else
    assign conflict = 1'b0;
`endif

endmodule

// File: tb/tb_tl_traffic_gen.sv
// Testbench for tl_traffic_gen: directed scenarios plus randomized traffic,
// checked through a scoreboard against a lane-level queue model.
module tb_tl_traffic_gen;
    import tl_pkg::*;

    localparam int QW   = 4;
    localparam int QMAX = (1 << QW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    La, Lb;
    logic          arr_a, arr_b, arr_al, arr_bl;
    logic          Ta, Tb, Tal, Tbl;
    logic [QW-1:0] qa, qb, qal, qbl;
    logic [7:0]    departed;
    logic          overflow, conflict;

    tl_traffic_gen #(.QW(QW)) dut (
        .clk(clk), .reset(reset), .La(La), .Lb(Lb),
        .arr_a(arr_a), .arr_b(arr_b), .arr_al(arr_al), .arr_bl(arr_bl),
        .Ta(Ta), .Tb(Tb), .Tal(Tal), .Tbl(Tbl),
        .qa(qa), .qb(qb), .qal(qal), .qbl(qbl),
        .departed(departed), .overflow(overflow), .conflict(conflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        int qa, qb, qal, qbl;
        int dep;
        bit ovf;
        bit conf;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference state: lane order 0=A, 1=B, 2=A-left, 3=B-left.
    int m_q[4];
    int m_dep;
    bit m_ovf;
    bit m_conf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and queue the state expected after the edge.
    task automatic step(input bit rst, input logic [1:0] la, input logic [1:0] lb,
                        input logic [3:0] arr);
        exp_t e;
        int   n_took;
        @(negedge clk);
        reset  = rst;
        La     = la;
        Lb     = lb;
        arr_a  = arr[0];
        arr_b  = arr[1];
        arr_al = arr[2];
        arr_bl = arr[3];
        if (rst) begin
            for (int i = 0; i < 4; i++) m_q[i] = 0;
            m_dep  = 0;
            m_ovf  = 0;
            m_conf = 0;
        end else begin
            n_took = 0;
            for (int i = 0; i < 4; i++) begin
                logic [1:0] light;
                bit         want;
                int         t;
                int         n;
                light = (i == 0 || i == 2) ? la : lb;
                want  = (i < 2) ? (light == GREEN) : (light == LEFT);
                t     = (want && m_q[i] > 0) ? 1 : 0;
                n     = m_q[i] - t + int'(arr[i]);
                if (n > QMAX) begin
                    n     = QMAX;
                    m_ovf = 1;
                end
                m_q[i] = n;
                n_took += t;
            end
            m_dep = (m_dep + n_took) % 256;
`ifdef TL_CONFLICT_CHK_EN
            if (la != RED && lb != RED) m_conf = 1;
`endif
        end
        e.qa   = m_q[0];
        e.qb   = m_q[1];
        e.qal  = m_q[2];
        e.qbl  = m_q[3];
        e.dep  = m_dep;
        e.ovf  = m_ovf;
        e.conf = m_conf;
        sb.push_back(e);
    endtask

    // Monitor: every edge that has a queued expectation is checked.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("qa",       32'(qa),       e.qa);
                chk("qb",       32'(qb),       e.qb);
                chk("qal",      32'(qal),      e.qal);
                chk("qbl",      32'(qbl),      e.qbl);
                chk("Ta",       32'(Ta),       32'(e.qa  != 0));
                chk("Tb",       32'(Tb),       32'(e.qb  != 0));
                chk("Tal",      32'(Tal),      32'(e.qal != 0));
                chk("Tbl",      32'(Tbl),      32'(e.qbl != 0));
                chk("departed", 32'(departed), e.dep);
                chk("overflow", 32'(overflow), 32'(e.ovf));
                chk("conflict", 32'(conflict), 32'(e.conf));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; La = RED; Lb = RED;
        arr_a = 1'b0; arr_b = 1'b0; arr_al = 1'b0; arr_bl = 1'b0;

        repeat (2) step(1, RED, RED, 4'b0000);

        // Three A arrivals under RED, then drain under GREEN.
        repeat (3) step(0, RED, RED, 4'b0001);
        repeat (5) step(0, GREEN, RED, 4'b0000);

        // A-left and B departing together.
        repeat (2) step(0, RED, RED, 4'b0100);
        step(0, RED, RED, 4'b0010);
        step(0, LEFT, GREEN, 4'b0000);
        step(0, RED, RED, 4'b0000);

        // Fill B-left to saturation, overflow, then arrival with departure at full.
        repeat (16) step(0, RED, RED, 4'b1000);
        step(0, RED, LEFT, 4'b1000);
        step(0, RED, RED, 4'b0000);

        // Reset mid-operation with an arrival in the reset cycle.
        step(1, RED, RED, 4'b0000);
        repeat (7) step(0, RED, RED, 4'b0001);
        step(1, RED, RED, 4'b0001);
        step(0, RED, RED, 4'b0000);

        // Steady flow: one in, one out each cycle; departed wraps.
        step(0, RED, RED, 4'b0001);
        repeat (300) step(0, GREEN, RED, 4'b0001);
        @(posedge clk);
        #2;
        chk("wrap_departed", 32'(departed), 32'(300 % 256));
        chk("wrap_qa",       32'(qa),       32'd1);

        // Random traffic with occasional resets.
        step(1, RED, RED, 4'b0000);
        for (int c = 0; c < 500; c++) begin
            bit         r;
            logic [1:0] la, lb;
            logic [3:0] arr;
            r   = ($urandom_range(0, 63) == 0);
            la  = 2'($urandom_range(0, 3));
            lb  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : RED;
            arr = 4'($urandom) & 4'($urandom);
            if (c % 100 < 30) arr = 4'hF;
            step(r, la, lb, arr);
        end

        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
